// File: rtl/word_serializer.sv
// Parallel-to-serial word transmitter, MSB first, with bit-valid strobe and done pulse.
// Optional even-parity trailer bit when the SER_PARITY_EN macro is defined.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for a load; ready=1
// ST_SHIFT   | driving word bits MSB..LSB, one per cycle
// ST_PARITY  | driving even parity of the loaded word (SER_PARITY_EN only)
// ST_DONE    | one-cycle completion pulse; a new load may be accepted here
module word_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             load,
  input  logic             abort,
  output logic             ready,
  output logic             serialOut,
  output logic             bitValid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY, ST_DONE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             load_ok;
`ifdef SER_PARITY_EN
  logic             par;
`endif

  // ready is pure state decode, so load acceptance never loops through an output
  assign ready   = (state == ST_IDLE) || (state == ST_DONE);
  assign load_ok = load && ready && !abort;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
`ifdef SER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (load_ok) begin
        shreg <= dataIn;
        cnt   <= CW'(WIDTH - 1);
`ifdef SER_PARITY_EN
        par   <= ^dataIn;
`endif
      end else if (state == ST_SHIFT) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        if (cnt != '0) cnt <= cnt - CW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (load_ok) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (abort) state_nxt = ST_IDLE;
        else if (cnt == '0) begin
`ifdef SER_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      ST_PARITY: state_nxt = abort ? ST_IDLE : ST_DONE;
`endif
      ST_DONE:  state_nxt = load_ok ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    serialOut = 1'b0;
    bitValid  = 1'b0;
    done      = (state == ST_DONE);
    if (state == ST_SHIFT) begin
      serialOut = shreg[WIDTH-1];
      bitValid  = 1'b1;
    end
`ifdef SER_PARITY_EN
    if (state == ST_PARITY) begin
      serialOut = par;
      bitValid  = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (WIDTH=32); parity checks apply when SER_PARITY_EN is defined.
module tb_word_serializer;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [31:0] dataIn = '0;
  logic        load = 1'b0;
  logic        abort = 1'b0;
  logic        ready, serialOut, bitValid, done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;

`ifdef SER_PARITY_EN
  localparam int DONE_CYC = 34;
`else
  localparam int DONE_CYC = 33;
`endif

  word_serializer #(.WIDTH(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .dataIn(dataIn), .load(load), .abort(abort),
    .ready(ready), .serialOut(serialOut), .bitValid(bitValid), .done(done)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (done) done_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a load in the current cycle (cycle 0) and step to cycle 1.
  task automatic start_frame(input logic [31:0] w);
    load = 1'b1; dataIn = w;
    @(negedge CLK);
    load = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // From cycle 1, check every data bit of the frame, leaving the bench at cycle 33.
  task automatic check_bits(input string tag, input logic [31:0] w);
    for (int k = 1; k <= 32; k++) begin
      chk({tag, "_valid"}, 32'(bitValid), 32'd1);
      chk({tag, "_bit"}, 32'(serialOut), 32'(w[32-k]));
      @(negedge CLK);
    end
  endtask

  initial begin
    logic [31:0] w;
    #2;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(bitValid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sout", 32'(serialOut), 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;

    // first load right after reset release, A5000001
    w = 32'hA5000001;
    start_frame(w);
    chk("f1_ready", 32'(ready), 32'd0);
    check_bits("f1", w);
`ifdef SER_PARITY_EN
    chk("f1_par_valid", 32'(bitValid), 32'd1);
    chk("f1_par", 32'(serialOut), 32'd1);
    chk("f1_par_done", 32'(done), 32'd0);
    @(negedge CLK);
`endif
    chk("f1_done", 32'(done), 32'd1);
    chk("f1_done_ready", 32'(ready), 32'd1);
    chk("f1_done_valid", 32'(bitValid), 32'd0);
    @(negedge CLK);
    chk("f1_idle_done", 32'(done), 32'd0);
    chk("f1_idle_ready", 32'(ready), 32'd1);

    // all-ones word; a load during SHIFT in cycle 5 must be ignored
    w = 32'hFFFFFFFF;
    start_frame(w);
    for (int k = 1; k <= 32; k++) begin
      load = (k == 5); dataIn = (k == 5) ? 32'h0 : w;
      chk("f2_bit", 32'(serialOut), 32'd1);
      chk("f2_valid", 32'(bitValid), 32'd1);
      @(negedge CLK);
    end
    load = 1'b0;
    step(DONE_CYC - 33);
    chk("f2_done", 32'(done), 32'd1);
    @(negedge CLK);
    chk("f2_after_valid", 32'(bitValid), 32'd0);
    chk("f2_after_ready", 32'(ready), 32'd1);

    // abort in cycle 10: no done ever
    done_seen = 0;
    start_frame(32'h12345678);
    step(9);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("ab_valid", 32'(bitValid), 32'd0);
    chk("ab_ready", 32'(ready), 32'd1);
    step(40);
    chk("ab_no_done", 32'(done_seen), 32'd0);

    // async reset mid-cycle 7
    done_seen = 0;
    start_frame(32'hFFFFFFFF);
    step(6);
    #2 RESETn = 1'b0;
    #1;
    chk("ar_ready", 32'(ready), 32'd1);
    chk("ar_valid", 32'(bitValid), 32'd0);
    chk("ar_sout", 32'(serialOut), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    step(3);
    RESETn = 1'b1;
    start_frame(32'h80000000);
    chk("ar_first_valid", 32'(bitValid), 32'd1);
    chk("ar_first_bit", 32'(serialOut), 32'd1);
    step(40);
    chk("ar_one_done", 32'(done_seen), 32'd1);

    // load together with abort in IDLE: nothing starts
    load = 1'b1; abort = 1'b1; dataIn = 32'hFFFFFFFF;
    @(negedge CLK);
    load = 1'b0; abort = 1'b0;
    chk("la_ready", 32'(ready), 32'd1);
    chk("la_valid", 32'(bitValid), 32'd0);

    // back-to-back: load 80000000 in DONE of a 0x00000001 frame
    start_frame(32'h00000001);
    step(DONE_CYC - 1);
    chk("bb_done", 32'(done), 32'd1);
    load = 1'b1; dataIn = 32'h80000000;
    @(negedge CLK);
    load = 1'b0;
    chk("bb_valid", 32'(bitValid), 32'd1);
    chk("bb_bit", 32'(serialOut), 32'd1);
    chk("bb_ready", 32'(ready), 32'd0);
    @(negedge CLK);
    chk("bb_bit2", 32'(serialOut), 32'd0);
    step(DONE_CYC - 2);
    chk("bb2_done", 32'(done), 32'd1);

    // abort with load in DONE: pulse completes, load blocked
    abort = 1'b1; load = 1'b1; dataIn = 32'hFFFFFFFF;
    @(negedge CLK);
    abort = 1'b0; load = 1'b0;
    chk("ad_ready", 32'(ready), 32'd1);
    chk("ad_valid", 32'(bitValid), 32'd0);
    chk("ad_done", 32'(done), 32'd0);

`ifdef SER_PARITY_EN
    start_frame(32'h00000007);
    step(32);
    chk("p7_valid", 32'(bitValid), 32'd1);
    chk("p7_par", 32'(serialOut), 32'd1);
    @(negedge CLK);
    chk("p7_done", 32'(done), 32'd1);
    @(negedge CLK);
    start_frame(32'h00000003);
    step(32);
    chk("p3_valid", 32'(bitValid), 32'd1);
    chk("p3_par", 32'(serialOut), 32'd0);
    step(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter WIDTH, default 32, sets the parallel word width in bits; legal range 2..32.
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RESETn  input  1  asynchronous, active-low reset.
REQ-004 dataIn  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
REQ-005 load  input  1  load request; accepted when load=1, ready=1 and abort=0 at a rising edge.
REQ-006 abort  input  1  synchronous frame cancel.
REQ-007 ready  output  1  high when idle and able to accept a load.
REQ-008 serialOut  output  1  serial data bit, MSB first.
REQ-009 bitValid  output  1  high in every cycle in which serialOut carries a frame bit.
REQ-010 done  output  1  one-cycle pulse marking normal frame completion.

Function
REQ-011 The block SHALL implement the states IDLE, SHIFT, PARITY (present only with SER_PARITY_EN) and DONE, with all outputs driven from registers or state decode with no combinational path from inputs.
REQ-012 In IDLE the block SHALL drive ready=1, bitValid=0, done=0 and serialOut=0.
REQ-013 An accepted load SHALL capture dataIn into the shift register, set the bit counter to WIDTH-1 and move to SHIFT.
REQ-014 If the load is accepted at the edge ending cycle 0, then cycles 1..WIDTH SHALL drive bitValid=1 and serialOut=dataIn[WIDTH-1]..dataIn[0], in that order.
REQ-015 In SHIFT the block SHALL drive ready=0, shift the register left by one and decrement the counter at each edge.
REQ-016 When the counter reaches 0, the next state SHALL be PARITY if SER_PARITY_EN is defined, otherwise DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, ready=1 and bitValid=0, followed by IDLE.
REQ-018 A load accepted in DONE SHALL start a new frame, giving a one-cycle gap between frames.
REQ-019 A load while ready=0 SHALL be ignored, with no effect on the shift register or counter.
REQ-020 abort=1 in SHIFT or PARITY SHALL move the block to IDLE at the next edge with no done pulse; the next cycle SHALL show bitValid=0 and ready=1.
REQ-021 abort=1 together with load=1 SHALL cancel the load (abort has priority).
REQ-022 abort in IDLE or DONE SHALL have no effect other than blocking a simultaneous load; the DONE pulse still completes.
REQ-023 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap below 0.

Reset
REQ-024 RESETn=0 SHALL immediately, independent of CLK, force state=IDLE, clear the shift register and counter, and drive ready=1, serialOut=0, bitValid=0 and done=0.
REQ-025 A reset during a frame SHALL discard the frame without a done pulse.
REQ-026 The first load after RESETn deasserts SHALL be accepted at the first rising edge at which it is high.

Configuration
REQ-027 With macro SER_PARITY_EN defined, the block SHALL insert a PARITY cycle after bit 0, driving bitValid=1 and serialOut equal to the XOR of the loaded word (even parity); DONE follows in cycle WIDTH+2.
REQ-028 Without SER_PARITY_EN, the PARITY state and its logic SHALL be absent and DONE SHALL occur in cycle WIDTH+1.

Verification
REQ-029 Load 0xA5000001 with no macro -> cycles 1..8 serialOut 1,0,1,0,0,1,0,1; cycles 9..31 give 0; cycle 32 gives 1; cycle 33 done=1.
REQ-030 Load 0xFFFFFFFF, then load 0x00000000 in cycle 5 -> all 32 bits are 1, and the second word is never transmitted.
REQ-031 Load 0x12345678 with abort=1 in cycle 10 -> cycle 11 shows bitValid=0, ready=1, and no done pulse ever occurs.
REQ-032 Assert RESETn=0 mid-cycle 7 of a frame -> outputs reach reset values before the next edge; no done pulse.
REQ-033 With SER_PARITY_EN, load 0x00000007 -> cycle 33 gives bitValid=1, serialOut=1; cycle 34 gives done=1. Load 0x00000003 -> cycle 33 gives serialOut=0.
REQ-034 In IDLE, drive load=1 and abort=1 together -> no frame starts and ready stays 1; then load 0x80000000 in DONE of a frame -> new frame's first bit is 1, one cycle after done.
